// File: rtl/hb_wb_pkg.sv
// Shared types and defaults for the hostbus-to-Wishbone bridge.
package hb_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int SYNC_DEF    = 2;
  localparam int TIMEOUT_DEF = 255;

  // Width of the CYCLE clock counter; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/hb_wb_bridge_sync.sv
// Flop-chain synchroniser for one asynchronous, active-low hostbus strobe.
module hb_sync
  import hb_wb_pkg::*;
#(
  parameter int STAGES = SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Resets to 1 so the strobes read as inactive until the host drives them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hb_wb_bridge.sv
// Hostbus slave port to single classic Wishbone master cycles, with host wait,
// byte enables, error/timeout termination and a sticky error flag.
module hb_wb_bridge
  import hb_wb_pkg::*;
#(
  parameter int            AW          = AW_DEF,
  parameter int            DW          = DW_DEF,
  parameter int            SYNC_STAGES = SYNC_DEF,
  parameter int            TIMEOUT     = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_DATA    = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hb_cs,
  input  logic            hb_oe,
  input  logic            hb_we,
  input  logic [DW/8-1:0] hb_be,
  input  logic [AW-1:0]   hb_addr,
  inout  wire  [DW-1:0]   hb_data,
  output logic            hb_wait,
  output logic            wb_cyc,
  output logic            wb_stb,
  output logic            wb_we,
  output logic [DW/8-1:0] wb_sel,
  output logic [AW-1:0]   wb_addr,
  output logic [DW-1:0]   wb_wdata,
  input  logic [DW-1:0]   wb_rdata,
  input  logic            wb_ack,
  input  logic            wb_err,
  output logic            err_flag,
  input  logic            err_clr
);

  localparam int BW = DW / 8;
  localparam int CW = cnt_width(TIMEOUT);

  logic cs_s, oe_s, we_s;

  hb_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .rst(rst), .d(hb_cs), .q(cs_s));
  hb_sync #(.STAGES(SYNC_STAGES)) u_sync_oe (.clk(clk), .rst(rst), .d(hb_oe), .q(oe_s));
  hb_sync #(.STAGES(SYNC_STAGES)) u_sync_we (.clk(clk), .rst(rst), .d(hb_we), .q(we_s));

  state_t          state, state_n;
  logic            cyc_q, cyc_n;
  logic            we_q, we_n;
  logic [BW-1:0]   sel_q, sel_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic [DW-1:0]   rd_reg, rd_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            err_set;
  logic            timeout_hit;
  logic            data_oe;

  // cnt holds the number of CYCLE clocks already elapsed, so the edge that
  // sees TIMEOUT-1 is the T-th clock with cyc high.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    cyc_n   = cyc_q;
    we_n    = we_q;
    sel_n   = sel_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rd_n    = rd_reg;
    cnt_n   = cnt_q;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s && (!oe_s || !we_s)) begin
          state_n = CYCLE;
          cyc_n   = 1'b1;
          we_n    = !we_s;
          addr_n  = hb_addr;
          cnt_n   = '0;
          if (!we_s) begin
            wdata_n = hb_data;
            sel_n   = ~hb_be;
          end else begin
            sel_n   = '1;
          end
        end
      end
      CYCLE: begin
        cnt_n = cnt_q + 1'b1;
        // An aborted access still terminates on the bus but skips DONE and
        // leaves rd_reg untouched, so nothing stale is ever presented.
        if (wb_err || wb_ack || timeout_hit) begin
          cyc_n   = 1'b0;
          state_n = cs_s ? IDLE : DONE;
          if (wb_err || !wb_ack) begin
            err_set = 1'b1;
            if (!cs_s) rd_n = ERR_DATA;
          end else if (!we_q && !cs_s) begin
            rd_n = wb_rdata;
          end
        end
      end
      DONE: begin
        if (cs_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_reg   <= '0;
      cnt_q    <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_n;
      cyc_q    <= cyc_n;
      we_q     <= we_n;
      sel_q    <= sel_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      rd_reg   <= rd_n;
      cnt_q    <= cnt_n;
      if (err_set)      err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end

  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = we_q;
  assign wb_sel   = sel_q;
  assign wb_addr  = addr_q;
  assign wb_wdata = wdata_q;

  // Host-facing strobes use the raw pins so the host sees release immediately.
  assign data_oe = !hb_cs && !hb_oe && hb_we && (state == DONE);
  assign hb_data = data_oe ? rd_reg : {DW{1'bz}};
  assign hb_wait = !(!hb_cs && (state != DONE));

endmodule

// File: tb/tb_hb_wb_bridge.sv
// Directed bench for hb_wb_bridge: read, write, timeout, error/clear, abort, reset.
module tb_hb_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        hb_cs, hb_oe, hb_we;
  logic [1:0]  hb_be;
  logic [15:0] hb_addr;
  wire  [15:0] hb_data;
  logic        hb_wait;
  logic        wb_cyc, wb_stb, wb_we;
  logic [1:0]  wb_sel;
  logic [15:0] wb_addr, wb_wdata, wb_rdata;
  logic        wb_ack, wb_err;
  logic        err_flag, err_clr;

  logic        drv_en;
  logic [15:0] drv_val;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_clks  = 0;
  int cyc_rises = 0;
  logic cyc_d = 1'b0;

  assign hb_data = drv_en ? drv_val : 16'hzzzz;
  pulldown (hb_data);

  always #5 clk = ~clk;

  hb_wb_bridge #(
    .AW(16), .DW(16), .SYNC_STAGES(2), .TIMEOUT(8), .ERR_DATA(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst),
    .hb_cs(hb_cs), .hb_oe(hb_oe), .hb_we(hb_we), .hb_be(hb_be),
    .hb_addr(hb_addr), .hb_data(hb_data), .hb_wait(hb_wait),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .err_flag(err_flag), .err_clr(err_clr)
  );

  always @(negedge clk) begin
    if (wb_cyc) cyc_clks++;
    if (wb_cyc && !cyc_d) cyc_rises++;
    cyc_d = wb_cyc;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic start_access(input logic [15:0] a, input bit wr,
                              input logic [15:0] d, input logic [1:0] be);
    hb_addr = a;
    hb_be   = be;
    if (wr) begin
      drv_val = d; drv_en = 1'b1; hb_we = 1'b0; hb_oe = 1'b1;
    end else begin
      drv_en = 1'b0; hb_we = 1'b1; hb_oe = 1'b0;
    end
    hb_cs = 1'b0;
  endtask

  task automatic end_access();
    hb_cs = 1'b1; hb_oe = 1'b1; hb_we = 1'b1; drv_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_cyc(input string tag);
    for (int i = 0; i < 10 && !wb_cyc; i++) @(negedge clk);
    check(tag, {31'd0, wb_cyc}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hb_cs = 1'b1; hb_oe = 1'b1; hb_we = 1'b1; hb_be = 2'b11;
    hb_addr = '0; drv_en = 1'b0; drv_val = '0;
    wb_rdata = '0; wb_ack = 1'b0; wb_err = 1'b0; err_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cyc",   {31'd0, wb_cyc},   32'd0);
    check("rst_sel",   {30'd0, wb_sel},   32'd0);
    check("rst_addr",  {16'd0, wb_addr},  32'd0);
    check("rst_wdata", {16'd0, wb_wdata}, 32'd0);
    check("rst_err",   {31'd0, err_flag}, 32'd0);
    check("rst_wait",  {31'd0, hb_wait},  32'd1);
    check("rst_data",  {16'd0, hb_data},  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read: addr 3, ack 3 clocks after stb with AAAA
    cyc_clks = 0;
    start_access(16'h0003, 1'b0, 16'h0000, 2'b11);
    #1 check("rd_wait_start", {31'd0, hb_wait}, 32'd0);
    repeat (2) @(negedge clk);
    check("rd_cyc_early", {31'd0, wb_cyc}, 32'd0);
    @(negedge clk);
    check("rd_cyc_lat", {31'd0, wb_cyc}, 32'd1);
    check("rd_stb",     {31'd0, wb_stb}, 32'd1);
    check("rd_addr",    {16'd0, wb_addr}, 32'h0003);
    check("rd_we",      {31'd0, wb_we},  32'd0);
    check("rd_sel",     {30'd0, wb_sel}, 32'd3);
    repeat (2) @(negedge clk);
    check("rd_wait_cyc", {31'd0, hb_wait}, 32'd0);
    wb_ack = 1'b1; wb_rdata = 16'hAAAA;
    @(negedge clk);
    wb_ack = 1'b0;
    check("rd_cyc_end",  {31'd0, wb_cyc},  32'd0);
    check("rd_cyc_clks", cyc_clks,         32'd3);
    check("rd_wait_done",{31'd0, hb_wait}, 32'd1);
    check("rd_data",     {16'd0, hb_data}, 32'h0000AAAA);
    hb_cs = 1'b1;
    #1 check("rd_data_rel", {16'd0, hb_data}, 32'd0);
    end_access();

    // Write: F0F0 with hb_be=10, zero-wait ack, one cycle per cs
    cyc_rises = 0;
    start_access(16'h0010, 1'b1, 16'hF0F0, 2'b10);
    wait_cyc("wr_start");
    check("wr_we",    {31'd0, wb_we},    32'd1);
    check("wr_wdata", {16'd0, wb_wdata}, 32'h0000F0F0);
    check("wr_sel",   {30'd0, wb_sel},   32'd1);
    check("wr_addr",  {16'd0, wb_addr},  32'h0010);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check("wr_cyc_end", {31'd0, wb_cyc}, 32'd0);
    repeat (5) @(negedge clk);
    check("wr_one_cycle", cyc_rises, 32'd1);
    check("wr_wait_done", {31'd0, hb_wait}, 32'd1);
    check("wr_no_err",    {31'd0, err_flag}, 32'd0);
    end_access();

    // Timeout: read with no response, T=8
    cyc_clks = 0;
    start_access(16'h0005, 1'b0, 16'h0000, 2'b11);
    wait_cyc("to_start");
    repeat (10) @(negedge clk);
    check("to_cyc_clks", cyc_clks,          32'd8);
    check("to_cyc_end",  {31'd0, wb_cyc},   32'd0);
    check("to_data",     {16'd0, hb_data},  32'h0000FFFF);
    check("to_err",      {31'd0, err_flag}, 32'd1);
    end_access();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", {31'd0, err_flag}, 32'd0);

    // Error on a write coincident with err_clr: set wins
    start_access(16'h0007, 1'b1, 16'h1234, 2'b00);
    wait_cyc("er_start");
    check("er_sel", {30'd0, wb_sel}, 32'd3);
    wb_err = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    wb_err = 1'b0; err_clr = 1'b0;
    check("er_cyc_end", {31'd0, wb_cyc},   32'd0);
    check("er_flag",    {31'd0, err_flag}, 32'd1);
    end_access();

    // Abort: cs released during CYCLE, ack 5 clocks after stb
    cyc_clks = 0;
    start_access(16'h0009, 1'b0, 16'h0000, 2'b11);
    wait_cyc("ab_start");
    hb_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("ab_cyc_held", {31'd0, wb_cyc}, 32'd1);
    wb_ack = 1'b1; wb_rdata = 16'hBBBB;
    @(negedge clk);
    wb_ack = 1'b0;
    check("ab_cyc_end",  {31'd0, wb_cyc},  32'd0);
    check("ab_cyc_clks", cyc_clks,         32'd5);
    for (int i = 0; i < 3; i++) begin
      check("ab_data_z", {16'd0, hb_data}, 32'd0);
      @(negedge clk);
    end
    end_access();

    // Next read after abort proceeds normally
    start_access(16'h000B, 1'b0, 16'h0000, 2'b11);
    #1 check("nx_wait_start", {31'd0, hb_wait}, 32'd0);
    wait_cyc("nx_start");
    check("nx_addr", {16'd0, wb_addr}, 32'h000B);
    wb_ack = 1'b1; wb_rdata = 16'h5555;
    @(negedge clk);
    wb_ack = 1'b0;
    check("nx_data", {16'd0, hb_data}, 32'h00005555);
    check("nx_wait", {31'd0, hb_wait}, 32'd1);
    end_access();

    // Reset asserted mid-CYCLE (err_flag is still set from the error case)
    start_access(16'h0001, 1'b0, 16'h0000, 2'b11);
    wait_cyc("rm_start");
    rst = 1'b1;
    #1;
    check("rm_cyc",  {31'd0, wb_cyc},   32'd0);
    check("rm_err",  {31'd0, err_flag}, 32'd0);
    check("rm_data", {16'd0, hb_data},  32'd0);
    check("rm_wait_low", {31'd0, hb_wait}, 32'd0);
    hb_cs = 1'b1; hb_oe = 1'b1;
    #1 check("rm_wait_high", {31'd0, hb_wait}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
